// File: rtl/ex_mem_flags_if.sv
// EX -> MEM pipeline bundle: execute-stage inputs, memory-stage outputs, flag register
// and branch decision.
interface ex_mem_flags_if;
  // Pipeline control
  logic        stall;
  logic        flush;

  // Execute-stage instruction
  logic        ex_valid;
  logic [2:0]  ex_ctl;
  logic        ex_flag_we;
  logic [15:0] alu_result;
  logic [2:0]  alu_flags;
  logic [3:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic [15:0] ex_store_data;

  // Branch resolution
  logic        br_check;
  logic [2:0]  br_cond;

  // Memory-stage copies
  logic        mem_valid;
  logic [15:0] mem_result;
  logic [15:0] mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_reg_we;
  logic        mem_mem_re;
  logic        mem_mem_we;

  // Architectural flags and branch decision
  logic [2:0]  flags_q;
  logic        br_taken;

  modport master (
    output stall, flush, ex_valid, ex_ctl, ex_flag_we, alu_result, alu_flags, ex_rd,
           ex_reg_we, ex_mem_re, ex_mem_we, ex_store_data, br_check, br_cond,
    input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_we, mem_mem_re,
           mem_mem_we, flags_q, br_taken
  );

  modport slave (
    input  stall, flush, ex_valid, ex_ctl, ex_flag_we, alu_result, alu_flags, ex_rd,
           ex_reg_we, ex_mem_re, ex_mem_we, ex_store_data, br_check, br_cond,
    output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_we, mem_mem_re,
           mem_mem_we, flags_q, br_taken
  );
endinterface

// File: rtl/ex_mem_flags.sv
// EX/MEM pipeline register with the architectural Z/V/N flag register and a branch
// condition evaluator that sees the flags being written this cycle.
module ex_mem_flags (
  input logic           clk,
  input logic           rst_n,
  ex_mem_flags_if.slave bus
);

  typedef enum logic [2:0] {
    CtlAdd    = 3'b000,
    CtlSub    = 3'b001,
    CtlPaddsb = 3'b010,
    CtlRed    = 3'b011,
    CtlSll    = 3'b100,
    CtlSra    = 3'b101,
    CtlRor    = 3'b110,
    CtlXor    = 3'b111
  } alu_ctl_e;

  typedef enum logic [2:0] {
    CondNe = 3'b000,
    CondEq = 3'b001,
    CondGt = 3'b010,
    CondLt = 3'b011,
    CondGe = 3'b100,
    CondLe = 3'b101,
    CondOv = 3'b110,
    CondUn = 3'b111
  } br_cond_e;

  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 0;

  // Flag register
  logic [2:0]  flags_reg_q, flags_d;
  logic        upd;

  // EX/MEM register
  logic        mem_valid_q,  mem_valid_d;
  logic [15:0] mem_result_q, mem_result_d;
  logic [15:0] mem_sdata_q,  mem_sdata_d;
  logic [3:0]  mem_rd_q,     mem_rd_d;
  logic        mem_reg_we_q, mem_reg_we_d;
  logic        mem_mem_re_q, mem_mem_re_d;
  logic        mem_mem_we_q, mem_mem_we_d;

  // Branch evaluation
  logic        flag_z, flag_v, flag_n;
  logic        cond_met;

  assign upd = bus.ex_valid & bus.ex_flag_we & ~bus.stall & ~bus.flush;

  // Flag merge: arithmetic ops write all three flags, shifts/XOR only Z.
  always_comb begin
    flags_d = flags_reg_q;
    if (upd) begin
      case (alu_ctl_e'(bus.ex_ctl))
        CtlAdd, CtlSub:                 flags_d = bus.alu_flags;
        CtlSll, CtlSra, CtlRor, CtlXor: flags_d[FlagZ] = bus.alu_flags[FlagZ];
        CtlPaddsb, CtlRed:              flags_d = flags_reg_q;
        default:                        flags_d = flags_reg_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg_q <= 3'b000;
    end else begin
      flags_reg_q <= flags_d;
    end
  end

  // Branches resolve against flags_d so they see the instruction currently in EX.
  assign flag_z = flags_d[FlagZ];
  assign flag_v = flags_d[FlagV];
  assign flag_n = flags_d[FlagN];

  always_comb begin
    cond_met = 1'b0;
    case (br_cond_e'(bus.br_cond))
      CondNe:  cond_met = ~flag_z;
      CondEq:  cond_met = flag_z;
      CondGt:  cond_met = ~flag_z & ~flag_n;
      CondLt:  cond_met = flag_n;
      CondGe:  cond_met = flag_z | (~flag_z & ~flag_n);
      CondLe:  cond_met = flag_n | flag_z;
      CondOv:  cond_met = flag_v;
      CondUn:  cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  assign bus.br_taken = bus.br_check & cond_met;

  // Flush drops the slot but leaves data fields alone; enables are gated by ex_valid.
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_result_d = mem_result_q;
    mem_sdata_d  = mem_sdata_q;
    mem_rd_d     = mem_rd_q;
    mem_reg_we_d = mem_reg_we_q;
    mem_mem_re_d = mem_mem_re_q;
    mem_mem_we_d = mem_mem_we_q;
    if (bus.flush) begin
      mem_valid_d  = 1'b0;
      mem_reg_we_d = 1'b0;
      mem_mem_re_d = 1'b0;
      mem_mem_we_d = 1'b0;
    end else if (!bus.stall) begin
      mem_valid_d  = bus.ex_valid;
      mem_result_d = bus.alu_result;
      mem_sdata_d  = bus.ex_store_data;
      mem_rd_d     = bus.ex_rd;
      mem_reg_we_d = bus.ex_reg_we & bus.ex_valid;
      mem_mem_re_d = bus.ex_mem_re & bus.ex_valid;
      mem_mem_we_d = bus.ex_mem_we & bus.ex_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q  <= 1'b0;
      mem_result_q <= 16'h0000;
      mem_sdata_q  <= 16'h0000;
      mem_rd_q     <= 4'h0;
      mem_reg_we_q <= 1'b0;
      mem_mem_re_q <= 1'b0;
      mem_mem_we_q <= 1'b0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_result_q <= mem_result_d;
      mem_sdata_q  <= mem_sdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_reg_we_q <= mem_reg_we_d;
      mem_mem_re_q <= mem_mem_re_d;
      mem_mem_we_q <= mem_mem_we_d;
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_result     = mem_result_q;
  assign bus.mem_store_data = mem_sdata_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_reg_we     = mem_reg_we_q;
  assign bus.mem_mem_re     = mem_mem_re_q;
  assign bus.mem_mem_we     = mem_mem_we_q;
  assign bus.flags_q        = flags_reg_q;

endmodule

// File: tb/tb_ex_mem_flags.sv
// Randomized scoreboard bench for ex_mem_flags: a reference model queues the expected
// branch decision and post-edge state, and two monitors compare against the DUT.
module tb_ex_mem_flags;

  logic clk;
  logic rst_n;

  ex_mem_flags_if bus ();

  ex_mem_flags dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        stall, flush, valid;
    logic [2:0]  ctl;
    logic        fwe;
    logic [15:0] res;
    logic [2:0]  af;
    logic [3:0]  rd;
    logic        rwe, mre, mwe;
    logic [15:0] sd;
    logic        chk;
    logic [2:0]  cond;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [15:0] res, sd;
    logic [3:0]  rd;
    logic        rwe, mre, mwe;
    logic [2:0]  flags;
    bit          known;
  } exp_t;

  exp_t state_q[$];
  bit   br_q[$];

  // Reference model state
  exp_t m;
  bit   z, v, n;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit cond_holds(input bit fz, input bit fv, input bit fn,
                                    input logic [2:0] code);
    case (code)
      3'd0:    return !fz;
      3'd1:    return fz;
      3'd2:    return !fz && !fn;
      3'd3:    return fn;
      3'd4:    return fz || !fn;
      3'd5:    return fn || fz;
      3'd6:    return fv;
      default: return 1'b1;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{stall: 0, flush: 0, valid: 0, ctl: 0, fwe: 0, res: 0, af: 0, rd: 0,
          rwe: 0, mre: 0, mwe: 0, sd: 0, chk: 0, cond: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.stall = ($urandom_range(0, 99) < 15);
    s.flush = ($urandom_range(0, 99) < 10);
    s.valid = ($urandom_range(0, 99) < 80);
    s.ctl   = 3'($urandom);
    s.fwe   = ($urandom_range(0, 99) < 70);
    s.res   = 16'($urandom);
    s.af    = 3'($urandom);
    s.rd    = 4'($urandom);
    s.rwe   = 1'($urandom);
    s.mre   = 1'($urandom);
    s.mwe   = 1'($urandom);
    s.sd    = 16'($urandom);
    s.chk   = 1'($urandom);
    s.cond  = 3'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.stall         = s.stall;
    bus.flush         = s.flush;
    bus.ex_valid      = s.valid;
    bus.ex_ctl        = s.ctl;
    bus.ex_flag_we    = s.fwe;
    bus.alu_result    = s.res;
    bus.alu_flags     = s.af;
    bus.ex_rd         = s.rd;
    bus.ex_reg_we     = s.rwe;
    bus.ex_mem_re     = s.mre;
    bus.ex_mem_we     = s.mwe;
    bus.ex_store_data = s.sd;
    bus.br_check      = s.chk;
    bus.br_cond       = s.cond;
  endtask

  // One cycle: drive at negedge, then queue what the DUT must show.
  task automatic drive(input stim_t s);
    @(negedge clk);
    apply(s);
    #1;
    if (s.valid && s.fwe && !s.stall && !s.flush) begin
      if (s.ctl == 3'd0 || s.ctl == 3'd1) begin
        z = s.af[2];
        v = s.af[1];
        n = s.af[0];
      end else if (s.ctl >= 3'd4) begin
        z = s.af[2];
      end
    end
    br_q.push_back(s.chk && cond_holds(z, v, n, s.cond));
    if (s.flush) begin
      m.valid = 0;
      m.rwe   = 0;
      m.mre   = 0;
      m.mwe   = 0;
      m.known = 0;
    end else if (!s.stall) begin
      m.valid = s.valid;
      m.res   = s.res;
      m.sd    = s.sd;
      m.rd    = s.rd;
      m.rwe   = s.rwe && s.valid;
      m.mre   = s.mre && s.valid;
      m.mwe   = s.mwe && s.valid;
      m.known = 1;
    end
    m.flags = {z, v, n};
    state_q.push_back(m);
  endtask

  task automatic model_reset();
    m = '{valid: 0, res: 0, sd: 0, rd: 0, rwe: 0, mre: 0, mwe: 0, flags: 0, known: 1};
    z = 0;
    v = 0;
    n = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_valid"}, 32'(bus.mem_valid), 0);
    check({tag, " flags_q"}, 32'(bus.flags_q), 0);
    check({tag, " mem_result"}, 32'(bus.mem_result), 0);
    check({tag, " mem_store_data"}, 32'(bus.mem_store_data), 0);
    check({tag, " mem_rd"}, 32'(bus.mem_rd), 0);
    check({tag, " mem_en"}, 32'({bus.mem_reg_we, bus.mem_mem_re, bus.mem_mem_we}), 0);
  endtask

  // Branch monitor: combinational decision, sampled after the negedge drive settles.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (br_q.size() > 0) begin
        bit eb;
        eb = br_q.pop_front();
        check("br_taken", 32'(bus.br_taken), 32'(eb));
      end
    end
  end

  // State monitor: registered outputs, sampled just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        exp_t e;
        e = state_q.pop_front();
        check("mem_valid", 32'(bus.mem_valid), 32'(e.valid));
        check("mem_reg_we", 32'(bus.mem_reg_we), 32'(e.rwe));
        check("mem_mem_re", 32'(bus.mem_mem_re), 32'(e.mre));
        check("mem_mem_we", 32'(bus.mem_mem_we), 32'(e.mwe));
        check("flags_q", 32'(bus.flags_q), 32'(e.flags));
        if (e.known) begin
          check("mem_result", 32'(bus.mem_result), 32'(e.res));
          check("mem_store_data", 32'(bus.mem_store_data), 32'(e.sd));
          check("mem_rd", 32'(bus.mem_rd), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    s = idle();
    s.chk  = 1;
    s.cond = 3'd0;
    apply(s);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset br NE", 32'(bus.br_taken), 1);
    #6 rst_n = 1'b1;

    // SUB sets Z and V; the branch sees it through the bypass.
    s = idle();
    s.valid = 1; s.ctl = 3'd1; s.fwe = 1; s.af = 3'b110; s.chk = 1; s.cond = 3'd1;
    drive(s);
    s = idle();
    s.chk = 1; s.cond = 3'd0;
    drive(s);

    // ADD -> 011, XOR writes only Z -> 111, PADDSB leaves flags alone.
    s = idle();
    s.valid = 1; s.ctl = 3'd0; s.fwe = 1; s.af = 3'b011;
    drive(s);
    s.ctl = 3'd7; s.af = 3'b100;
    drive(s);
    s.ctl = 3'd2; s.af = 3'b000; s.chk = 1; s.cond = 3'd6;
    drive(s);

    // Three-cycle stall with changing inputs, then release.
    for (int i = 0; i < 3; i++) begin
      s = rand_stim();
      s.stall = 1; s.flush = 0;
      drive(s);
    end
    s = rand_stim();
    s.stall = 0; s.flush = 0;
    drive(s);

    // Flush beats stall.
    s = idle();
    s.valid = 1; s.ctl = 3'd0; s.fwe = 1; s.af = 3'b101; s.rwe = 1;
    s.stall = 1; s.flush = 1;
    drive(s);

    // Clear flags, then an invalid slot must not write anything.
    s = idle();
    s.valid = 1; s.ctl = 3'd0; s.fwe = 1; s.af = 3'b000;
    drive(s);
    s = idle();
    s.valid = 0; s.mwe = 1; s.fwe = 1; s.ctl = 3'd0; s.af = 3'b111; s.chk = 1; s.cond = 3'd2;
    drive(s);
    s = idle();
    s.chk = 0; s.cond = 3'd7;
    drive(s);

    // Load something, then reset mid-cycle during a stall.
    s = rand_stim();
    s.valid = 1; s.stall = 0; s.flush = 0; s.ctl = 3'd0; s.fwe = 1; s.af = 3'b111;
    drive(s);
    s.stall = 1;
    drive(s);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    model_reset();
    #1 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      drive(rand_stim());
    end

    @(posedge clk);
    #2;
    check("scoreboard drained", 32'(state_q.size() + br_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_flags.md
# ex_mem_flags

Pipeline register between the execute stage (ALU) and the memory stage, owning the architectural Z/V/N flag register and the branch-condition evaluator. It captures the 16-bit ALU result, the 3-bit ALU flags and the instruction's control bits once per cycle. It applies the per-opcode flag-update rules and resolves the 3-bit branch condition against the freshest flag values, with same-cycle bypass.

## Interface
Parameters: none. Fixed widths: data 16, register index 4. Flag bit order on every flag bus is [2]=Z, [1]=V, [0]=N.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold every register
- flush  in  1  load a bubble into the EX/MEM register
- ex_valid  in  1  EX stage holds a real instruction
- ex_ctl  in  3  ALU ctl code of the EX instruction
- ex_flag_we  in  1  EX instruction is an ALU-class op eligible to write flags
- alu_result  in  16  ALU result
- alu_flags  in  3  ALU flags {Z,V,N}
- ex_rd  in  4  destination register
- ex_reg_we, ex_mem_re, ex_mem_we  in  1 each  writeback, load and store enables
- ex_store_data  in  16  store data
- br_check  in  1  a branch is resolving this cycle
- br_cond  in  3  branch condition code
- mem_valid  out  1  MEM stage instruction valid
- mem_result, mem_store_data  out  16 each  registered copies
- mem_rd  out  4; mem_reg_we, mem_mem_re, mem_mem_we  out  1 each  registered copies
- flags_q  out  3  architectural flag register
- br_taken  out  1  branch decision, combinational

## Operation
- Commit condition: upd = ex_valid & ex_flag_we & ~stall & ~flush.
- Flag writes by ex_ctl when upd:
  - 000 ADD, 001 SUB: Z, V and N all load from alu_flags.
  - 100 SLL, 101 SRA, 110 ROR, 111 XOR: only Z loads; V and N hold.
  - 010 PADDSB, 011 RED: no flag changes.
- flags_nxt is the merged value above when upd, otherwise flags_q. flags_q <= flags_nxt on every edge.
- Branch evaluation uses flags_nxt (bypass), so a branch sees the flags of the instruction currently in EX.
- Condition codes:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 unconditional: 1
- br_taken = br_check & cond(flags_nxt). It is 0 whenever br_check = 0.
- EX/MEM register priority: reset > flush > stall > load.
  - flush: mem_valid, mem_reg_we, mem_mem_re and mem_mem_we go to 0. Data fields may hold any value. Flags are not written.
  - stall (no flush): every register, including flags_q, holds.
  - load: all fields capture their EX inputs. mem_valid = ex_valid. The enable bits are ANDed with ex_valid, so an invalid slot never writes.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the top level): every registered output goes to 0, including flags_q = 000. br_taken then depends only on br_check and br_cond; for example code 000 with br_check = 1 gives br_taken = 1, because Z = 0.
- Latency: EX inputs appear on mem_* outputs 1 cycle later.
- Flag updates are visible on flags_q 1 cycle later, and on br_taken in the same cycle through the bypass.
- There is no combinational path from any mem_* output back to br_taken.
- Reset asserted mid-stall or mid-flush clears immediately. The first edge after deassert loads normally.
- stall and flush in the same cycle: flush wins.
- Back-to-back flag writers: each edge commits the newest value. There is no accumulation.

## Test plan
- Reset: rst_n = 0 asynchronously mid-cycle -> mem_valid = 0, flags_q = 000, all mem_* = 0 before the next edge.
- SUB, alu_flags = 110 (Z=1, V=1), ex_flag_we = 1 -> next cycle flags_q = 110. In the same cycle, br_check = 1 with br_cond = 001 gives br_taken = 1, and br_cond = 000 gives 0.
- flags_q = 011, then XOR with alu_flags = 100 -> flags_q = 111. Then PADDSB with alu_flags = 000 -> flags_q stays 111.
- stall held 3 cycles while the inputs change -> mem_* and flags_q are constant. On release, the current inputs load.
- flush and stall together with ADD, ex_reg_we = 1 -> mem_valid = 0, mem_reg_we = 0, flags_q unchanged.
- ex_valid = 0 with ex_mem_we = 1 -> mem_mem_we = 0, flags unchanged. With flags_q = 000 and br_cond = 010, br_taken = 1; with br_cond = 111 and br_check = 0, br_taken = 0.
